// File: rtl/hbv_pair_decoder.sv
// MP3 big_values Huffman pair decoder for linbits tables 16-31.
// Serial codeword + linbits + sign bits in, signed (x, y) pairs out.
module hbv_pair_decoder #(
  parameter int MAX_CODE_LEN = 19,
  parameter int MAX_LINBITS  = 13,
  parameter int OUT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              linbits,
  input  logic [8:0]              num_pairs,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic                    in_ready,
  output logic [4:0]              cb_len,
  output logic [MAX_CODE_LEN-1:0] cb_bits,
  input  logic                    cb_hit,
  input  logic [3:0]              cb_x,
  input  logic [3:0]              cb_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        x_val,
  output logic [OUT_W-1:0]        y_val,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    IDLE, CODE, XLIN, XSIGN, YLIN, YSIGN, OUT
  } state_t;

  localparam logic [4:0] CL = 5'(MAX_CODE_LEN);
  localparam logic [3:0] LM = 4'(MAX_LINBITS);

  state_t state;
  state_t code_nxt;
  logic [3:0] lb, ax, ay, lcnt;
  logic [8:0] np, pcnt;
  logic [MAX_LINBITS-1:0] xlin, ylin;
  logic xsign, ysign;
  logic hit, ovf, take, xs_n, ys_n;
  logic [OUT_W-1:0] xmag, ymag, x_nxt, y_nxt;
  logic [MAX_CODE_LEN-1:0] top_bit;

  function automatic state_t y_first(input logic [3:0] a,
                                     input logic [3:0] l);
    if (a == 4'd15 && l != 4'd0) return YLIN;
    if (a != 4'd0) return YSIGN;
    return OUT;
  endfunction

  function automatic state_t x_first(input logic [3:0] a,
                                     input logic [3:0] b,
                                     input logic [3:0] l);
    if (a == 4'd15 && l != 4'd0) return XLIN;
    if (a != 4'd0) return XSIGN;
    return y_first(b, l);
  endfunction

  assign hit = state == CODE && cb_len != 5'd0 && cb_hit;
  assign ovf = state == CODE && cb_len == CL && !cb_hit;
  assign code_nxt = x_first(cb_x, cb_y, lb);

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      CODE:                    in_ready = !hit && !ovf;
      XLIN, XSIGN, YLIN, YSIGN: in_ready = 1'b1;
      default:                 in_ready = 1'b0;
    endcase
  end

  assign take = in_valid && in_ready;

  // the final sign bit is folded in on the same edge that enters OUT
  assign xs_n  = (state == XSIGN) ? in_bit : xsign;
  assign ys_n  = (state == YSIGN) ? in_bit : ysign;
  assign xmag  = OUT_W'(ax) + OUT_W'(xlin);
  assign ymag  = OUT_W'(ay) + OUT_W'(ylin);
  assign x_nxt = xs_n ? -xmag : xmag;
  assign y_nxt = ys_n ? -ymag : ymag;

  assign top_bit = {in_bit, {(MAX_CODE_LEN-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lb        <= '0;
      np        <= '0;
      pcnt      <= '0;
      ax        <= '0;
      ay        <= '0;
      lcnt      <= '0;
      xlin      <= '0;
      ylin      <= '0;
      xsign     <= 1'b0;
      ysign     <= 1'b0;
      cb_len    <= '0;
      cb_bits   <= '0;
      out_valid <= 1'b0;
      x_val     <= '0;
      y_val     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            lb      <= (linbits > LM) ? LM : linbits;
            np      <= num_pairs;
            pcnt    <= '0;
            cb_len  <= '0;
            cb_bits <= '0;
            if (num_pairs == 9'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= CODE;
            end
          end
        end
        CODE: begin
          if (hit) begin
            ax    <= cb_x;
            ay    <= cb_y;
            xlin  <= '0;
            ylin  <= '0;
            xsign <= 1'b0;
            ysign <= 1'b0;
            lcnt  <= lb;
            state <= code_nxt;
            if (code_nxt == OUT) begin
              x_val     <= '0;
              y_val     <= '0;
              out_valid <= 1'b1;
            end
          end else if (ovf) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (take) begin
            cb_bits <= cb_bits | (top_bit >> cb_len);
            cb_len  <= cb_len + 5'd1;
          end
        end
        XLIN: begin
          if (take) begin
            xlin <= {xlin[MAX_LINBITS-2:0], in_bit};
            lcnt <= lcnt - 4'd1;
            if (lcnt == 4'd1) state <= XSIGN;
          end
        end
        XSIGN: begin
          if (take) begin
            xsign <= in_bit;
            lcnt  <= lb;
            state <= y_first(ay, lb);
            if (y_first(ay, lb) == OUT) begin
              x_val     <= x_nxt;
              y_val     <= y_nxt;
              out_valid <= 1'b1;
            end
          end
        end
        YLIN: begin
          if (take) begin
            ylin <= {ylin[MAX_LINBITS-2:0], in_bit};
            lcnt <= lcnt - 4'd1;
            if (lcnt == 4'd1) state <= YSIGN;
          end
        end
        YSIGN: begin
          if (take) begin
            ysign     <= in_bit;
            x_val     <= x_nxt;
            y_val     <= y_nxt;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pcnt      <= pcnt + 9'd1;
            if (pcnt + 9'd1 == np) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cb_len  <= '0;
              cb_bits <= '0;
              state   <= CODE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hbv_pair_decoder.md
Name: hbv_pair_decoder

Overview:
- Runtime-configurable MP3 big_values Huffman pair decoder for tables 16–31, the linbits-carrying tables.
- Consumes a serial bitstream one bit per handshake and accumulates the Huffman codeword.
- Queries an external combinational codebook for the codeword, then reads linbits and sign bits for x and y.
- Emits signed (x, y) pairs with valid/ready back-pressure, and decodes a programmed count of pairs per granule region.
- Sits between the bit-reservoir reader and the requantiser.

Parameters:
- MAX_CODE_LEN, 19: longest codeword accepted before error.
- MAX_LINBITS, 13: largest runtime linbits value supported.
- OUT_W, 16: width of signed x_val/y_val.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a region; honoured only when busy=0
- linbits  in  4  linbits for the region, latched on start; values > MAX_LINBITS are clamped
- num_pairs  in  9  pairs to decode (0..288), latched on start
- in_valid  in  1  in_bit valid
- in_bit  in  1  next stream bit, MSB-first order
- in_ready  out  1  bit accepted when in_valid&&in_ready
- cb_len  out  5  number of codeword bits accumulated
- cb_bits  out  MAX_CODE_LEN  codeword, left-aligned; unused LSBs are 0
- cb_hit  in  1  external codebook: (cb_bits, cb_len) is a valid code
- cb_x  in  4  codebook |x| (0..15)
- cb_y  in  4  codebook |y| (0..15)
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts pair
- x_val  out  OUT_W  signed x
- y_val  out  OUT_W  signed y
- busy  out  1  region in progress
- done  out  1  one-cycle pulse after the last pair is accepted
- err  out  1  one-cycle pulse on codeword overflow

Behaviour:
- Reset
  - State IDLE; all counters and registers cleared.
  - x_val=y_val=0; out_valid, in_ready, busy, done, err all 0; cb_len=0; cb_bits=0.
  - Applies from any state, mid-operation included; a partial pair is discarded.
- States: IDLE, CODE, XLIN, XSIGN, YLIN, YSIGN, OUT.
- IDLE
  - On start: latch linbits and num_pairs, clear pair_cnt, busy=1.
  - num_pairs=0: pulse done next cycle and stay in IDLE.
  - Otherwise go to CODE.
- CODE
  - Each accepted bit is written to cb_bits[MAX_CODE_LEN-1-cb_len]; cb_len increments.
  - When cb_len!=0 && cb_hit:
    - in_ready=0 that cycle; latch ax=cb_x, ay=cb_y; clear linval registers.
    - Next state is the first applicable of XLIN, XSIGN, YLIN, YSIGN, else OUT.
  - When cb_len==MAX_CODE_LEN && !cb_hit: pulse err, go to IDLE, busy=0, no done pulse.
- XLIN: entered iff ax==15 && linbits!=0. Shift linbits bits MSB-first into xlin (MAX_LINBITS wide).
- XSIGN: entered iff ax!=0. One bit; 1 means negative.
- YLIN / YSIGN: same rules using ay and ylin.
- Sign rule: a zero magnitude consumes no sign bit.
- Bit acceptance
  - in_ready=1 only in bit-consuming states, excluding the hit cycle in CODE.
  - Without in_valid, state holds and no bits are lost.
- Output arithmetic
  - Magnitude = abs + lin, zero-extended to OUT_W.
  - Negated in two's complement if the sign bit is 1.
  - x_val/y_val are registered on entry to OUT.
- OUT
  - out_valid=1 and x_val/y_val held stable until out_ready.
  - On acceptance, pair_cnt increments.
    - If pair_cnt+1==num_pairs: busy=0, done pulse, go to IDLE.
    - Else clear cb_len and cb_bits and go to CODE.
  - in_ready=0 throughout OUT.
- Latency: one cycle for the lookup after the final code bit; the pair is valid one cycle after the final sign or lin bit.
- start while busy is ignored. err and done are never asserted together.

Test Plan:
- linbits=4, num_pairs=1, codebook "1101"->(0,1), bits 1101,1 -> one output x=0, y=-1; done pulses one cycle after out_ready.
- Codebook "0011"->(15,15), linbits=4, bits 0011,0101,0,1111,1 -> x=+20, y=-30.
- linbits=13, same code, x lin=13 ones, x sign 0, y lin=13 zeros, y sign 1 -> x=+8206, y=-15.
- out_ready held low 5 cycles -> out_valid stays 1, values stable, in_ready=0; the next pair decodes correctly after release. Random in_valid gaps -> identical outputs.
- cb_hit tied 0, 19 bits fed -> err pulse after bit 19, state IDLE, busy=0, no done.
- num_pairs=0 -> done one cycle after start with no out_valid. rst asserted during YLIN -> next cycle all outputs 0 and state IDLE; a fresh start decodes normally.
